// File: rtl/input_route_unit.sv
// Input-port route unit: a small flit FIFO whose front flit is routed by
// dimension-order routing (XY or YX). Head flits compute and latch a route,
// body/tail flits reuse it, and orphan body/tail flits are dropped and counted.
module input_route_unit #(
    parameter int unsigned       DSIZE     = 32,
    parameter int unsigned       RRSIZE    = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic              ALGORITHM = 1'b0,
    parameter logic [2:0]        PORT      = 3'd0,
    parameter logic [RRSIZE-1:0] ROUTER_X  = '0,
    parameter logic [RRSIZE-1:0] ROUTER_Y  = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DSIZE-1:0]           in_data,
    input  logic [1:0]                 in_type,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DSIZE-1:0]           out_data,
    output logic [1:0]                 out_type,
    output logic [2:0]                 out_port,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // PORT is informational; it is only validated here alongside the other parameters.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PORT > 3'd4 || DSIZE < 2 * RRSIZE) begin : g_bad_params
        $error("input_route_unit: illegal parameter combination");
    end

    logic [DSIZE-1:0]  data_mem_q [DEPTH];
    logic [1:0]        type_mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    logic [2:0]        route_q, route_d;
    state_t            state_q, state_d;

    logic [DSIZE-1:0]  front_data;
    logic [1:0]        front_type;
    logic [RRSIZE-1:0] dest_x, dest_y;
    logic [2:0]        front_route;
    logic              has_flit, front_is_head;
    logic              push, pop, drop;

    function automatic logic [2:0] route_of(input logic [RRSIZE-1:0] dx,
                                            input logic [RRSIZE-1:0] dy);
        logic [2:0] x_dir, y_dir;
        x_dir = (dx > ROUTER_X) ? P_EAST  : (dx < ROUTER_X) ? P_WEST  : P_LOCAL;
        y_dir = (dy > ROUTER_Y) ? P_NORTH : (dy < ROUTER_Y) ? P_SOUTH : P_LOCAL;
        if (ALGORITHM == 1'b0) begin
            return (x_dir != P_LOCAL) ? x_dir : y_dir;
        end
        return (y_dir != P_LOCAL) ? y_dir : x_dir;
    endfunction

    assign front_data    = data_mem_q[rd_ptr_q];
    assign front_type    = type_mem_q[rd_ptr_q];
    assign dest_x        = front_data[DSIZE-1 -: RRSIZE];
    assign dest_y        = front_data[DSIZE-1-RRSIZE -: RRSIZE];
    assign front_route   = route_of(dest_x, dest_y);
    assign has_flit      = (count_q != '0);
    assign front_is_head = (front_type == T_HEAD) || (front_type == T_SINGLE);

    assign in_ready = (count_q < CW'(DEPTH));
    assign out_data = front_data;
    assign out_type = front_type;
    assign count    = count_q;
    assign drop_cnt = drop_q;

    assign push = in_valid && in_ready;
    assign pop  = (out_valid && out_ready) || drop;

    // Packet FSM: decide presentation, route selection, drops and next state.
    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        out_valid = 1'b0;
        out_port  = (state_q == ACTIVE) ? route_q : P_LOCAL;
        drop      = 1'b0;
        if (has_flit) begin
            if (front_is_head) begin
                // A head seen while ACTIVE acts as an implicit tail for the old packet.
                out_valid = 1'b1;
                out_port  = front_route;
                if (out_ready) begin
                    route_d = front_route;
                    state_d = (front_type == T_SINGLE) ? IDLE : ACTIVE;
                end
            end else if (state_q == ACTIVE) begin
                out_valid = 1'b1;
                out_port  = route_q;
                if (out_ready && front_type == T_TAIL) begin
                    state_d = IDLE;
                end
            end else begin
                drop = 1'b1;
            end
        end
    end

    // FIFO pointer, occupancy and drop counter next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            route_q  <= P_LOCAL;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            route_q  <= route_d;
            state_q  <= state_d;
        end
    end

    // Flit storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= in_data;
            type_mem_q[wr_ptr_q] <= in_type;
        end
    end

endmodule

// File: tb/tb_input_route_unit.sv
// Bench for input_route_unit: three instances (XY@(1,1), YX@(1,1), XY@(0,0))
// share one stimulus stream; table vectors, directed sequences and a random
// run checked against a queue-level packet model.
module tb_input_route_unit;

    localparam int DEPTH = 4;
    localparam int NI    = 3;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_type;

    logic [NI-1:0] ov, ir;
    logic [31:0]   od  [NI];
    logic [1:0]    ot  [NI];
    logic [2:0]    op  [NI];
    logic [2:0]    cnt [NI];
    logic [7:0]    dc  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_route_unit #(.DSIZE(32), .RRSIZE(8), .DEPTH(DEPTH), .ALGORITHM(1'b0), .PORT(3'd0),
                       .ROUTER_X(8'd1), .ROUTER_Y(8'd1)) u_xy11 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_type(in_type), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_type(ot[0]), .out_port(op[0]), .count(cnt[0]), .drop_cnt(dc[0]));

    input_route_unit #(.DSIZE(32), .RRSIZE(8), .DEPTH(DEPTH), .ALGORITHM(1'b1), .PORT(3'd1),
                       .ROUTER_X(8'd1), .ROUTER_Y(8'd1)) u_yx11 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_type(in_type), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_type(ot[1]), .out_port(op[1]), .count(cnt[1]), .drop_cnt(dc[1]));

    input_route_unit #(.DSIZE(32), .RRSIZE(8), .DEPTH(DEPTH), .ALGORITHM(1'b0), .PORT(3'd2),
                       .ROUTER_X(8'd0), .ROUTER_Y(8'd0)) u_xy00 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_type(in_type), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .out_type(ot[2]), .out_port(op[2]), .count(cnt[2]), .drop_cnt(dc[2]));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  t;
    } flit_t;

    flit_t      mbuf  [NI][DEPTH];
    int         mhead [NI];
    int         msize [NI];
    bit         mact  [NI];
    logic [2:0] mrq   [NI];
    int         mdrop [NI];

    function automatic logic [2:0] ref_route(input int k, input logic [31:0] d);
        int dx   = int'(d[31:24]);
        int dy   = int'(d[23:16]);
        int rc   = (k == 2) ? 0 : 1;
        int xdir = (dx > rc) ? 2 : (dx < rc) ? 4 : 0;
        int ydir = (dy > rc) ? 1 : (dy < rc) ? 3 : 0;
        if (k == 1) return 3'((ydir != 0) ? ydir : xdir);
        return 3'((xdir != 0) ? xdir : ydir);
    endfunction

    function automatic bit starts_packet(input logic [1:0] t);
        return (t == 2'b01) || (t == 2'b11);
    endfunction

    function automatic bit m_valid(input int k);
        if (msize[k] == 0) return 1'b0;
        return mact[k] || starts_packet(mbuf[k][mhead[k]].t);
    endfunction

    function automatic logic [2:0] m_port(input int k);
        flit_t f = mbuf[k][mhead[k]];
        return starts_packet(f.t) ? ref_route(k, f.d) : mrq[k];
    endfunction

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                mhead[k] = 0; msize[k] = 0; mact[k] = 0; mrq[k] = 0; mdrop[k] = 0;
            end else begin
                bit    was_full = (msize[k] == DEPTH);
                bit    pop      = 0;
                flit_t f        = mbuf[k][mhead[k]];
                if (msize[k] > 0) begin
                    if (m_valid(k)) begin
                        if (out_ready) begin
                            pop = 1;
                            if (f.t == 2'b01)      begin mact[k] = 1; mrq[k] = ref_route(k, f.d); end
                            else if (f.t == 2'b11) begin mact[k] = 0; mrq[k] = ref_route(k, f.d); end
                            else if (f.t == 2'b10) mact[k] = 0;
                        end
                    end else begin
                        pop = 1;
                        if (mdrop[k] < 255) mdrop[k]++;
                    end
                end
                if (pop) begin
                    mhead[k] = (mhead[k] + 1) % DEPTH;
                    msize[k]--;
                end
                if (in_valid && !was_full) begin
                    mbuf[k][(mhead[k] + msize[k]) % DEPTH] = '{d: in_data, t: in_type};
                    msize[k]++;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] d, input logic [1:0] t);
        in_valid = 1'b1; in_data = d; in_type = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_model();
        for (int k = 0; k < NI; k++) begin
            chk("rnd_valid", k, 32'(ov[k]), 32'(m_valid(k)));
            chk("rnd_ready", k, 32'(ir[k]), 32'(msize[k] < DEPTH));
            chk("rnd_count", k, 32'(cnt[k]), 32'(msize[k]));
            chk("rnd_drop",  k, 32'(dc[k]),  32'(mdrop[k]));
            if (m_valid(k)) begin
                chk("rnd_data", k, od[k], mbuf[k][mhead[k]].d);
                chk("rnd_type", k, 32'(ot[k]), 32'(mbuf[k][mhead[k]].t));
                chk("rnd_port", k, 32'(op[k]), 32'(m_port(k)));
            end
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0]        d;
        logic [1:0]         t;
        logic [NI-1:0][2:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] d, input logic [1:0] t,
                                input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2);
        vec_t v;
        v.d = d; v.t = t;
        v.exp[0] = p0; v.exp[1] = p1; v.exp[2] = p2;
        return v;
    endfunction

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // expected ports: {XY@(1,1), YX@(1,1), XY@(0,0)}
        tbl[0] = mk(32'h0201BBBB, 2'b11, 3'd2, 3'd2, 3'd2);
        tbl[1] = mk(32'h02001234, 2'b01, 3'd2, 3'd3, 3'd2);
        tbl[2] = mk(32'h0101CCCC, 2'b11, 3'd0, 3'd0, 3'd2);
        tbl[3] = mk(32'h00020000, 2'b11, 3'd4, 3'd1, 3'd1);
        tbl[4] = mk(32'h00005555, 2'b11, 3'd4, 3'd3, 3'd0);
        tbl[5] = mk(32'h03000000, 2'b01, 3'd2, 3'd3, 3'd2);
        tbl[6] = mk(32'h01030000, 2'b11, 3'd1, 3'd1, 3'd2);
        tbl[7] = mk(32'hFF010000, 2'b11, 3'd2, 3'd2, 3'd2);
        tbl[8] = mk(32'h01FF0000, 2'b11, 3'd1, 3'd1, 3'd2);
        tbl[9] = mk(32'h01000000, 2'b11, 3'd3, 3'd3, 3'd2);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_type = '0;
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("reset_valid", k, 32'(ov[k]), 32'd0);
            chk("reset_ready", k, 32'(ir[k]), 32'd1);
            chk("reset_count", k, 32'(cnt[k]), 32'd0);
            chk("reset_drop",  k, 32'(dc[k]),  32'd0);
            chk("reset_port",  k, 32'(op[k]),  32'd0);
        end
        reset = 1'b0;

        // single/head flits: one-cycle latency and route per mode/coordinates
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push1(tbl[i].d, tbl[i].t);
            for (int k = 0; k < NI; k++) begin
                chk("tbl_valid", k, 32'(ov[k]), 32'd1);
                chk("tbl_port",  k, 32'(op[k]), 32'(tbl[i].exp[k]));
                chk("tbl_data",  k, od[k], tbl[i].d);
            end
            tick();
            if (tbl[i].t == 2'b01) begin
                // tail with a different destination must keep the latched route
                push1(32'h00000000, 2'b10);
                for (int k = 0; k < NI; k++) begin
                    chk("tbl_tail_valid", k, 32'(ov[k]), 32'd1);
                    chk("tbl_tail_port",  k, 32'(op[k]), 32'(tbl[i].exp[k]));
                end
                tick();
            end
            for (int k = 0; k < NI; k++) begin
                chk("tbl_empty_valid", k, 32'(ov[k]),  32'd0);
                chk("tbl_empty_count", k, 32'(cnt[k]), 32'd0);
                chk("tbl_no_drop",     k, 32'(dc[k]),  32'd0);
            end
        end

        // all packets closed: a body flit now is an orphan and is dropped
        push1(32'h0202DEAD, 2'b00);
        for (int k = 0; k < NI; k++) begin
            chk("orphan_valid", k, 32'(ov[k]),  32'd0);
            chk("orphan_count", k, 32'(cnt[k]), 32'd1);
        end
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("orphan_drop",  k, 32'(dc[k]),  32'd1);
            chk("orphan_count0", k, 32'(cnt[k]), 32'd0);
        end

        // fill to DEPTH with a 4-flit packet while stalled, then drain in order
        begin
            flit_t pk [4];
            logic [2:0] pexp [NI];
            pk[0] = '{d: 32'h00020000, t: 2'b01};
            pk[1] = '{d: 32'h0000AAAA, t: 2'b00};
            pk[2] = '{d: 32'h0000BBBB, t: 2'b00};
            pk[3] = '{d: 32'h0000CCCC, t: 2'b10};
            pexp[0] = 3'd4; pexp[1] = 3'd1; pexp[2] = 3'd1;
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) push1(pk[i].d, pk[i].t);
            push1(32'h12345678, 2'b00);
            for (int k = 0; k < NI; k++) begin
                chk("full_count", k, 32'(cnt[k]), 32'd4);
                chk("full_ready", k, 32'(ir[k]),  32'd0);
                chk("stall_data", k, od[k], pk[0].d);
                chk("stall_port", k, 32'(op[k]), 32'(pexp[k]));
            end
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < NI; k++) begin
                    chk("drain_valid", k, 32'(ov[k]), 32'd1);
                    chk("drain_data",  k, od[k], pk[i].d);
                    chk("drain_type",  k, 32'(ot[k]), 32'(pk[i].t));
                    chk("drain_port",  k, 32'(op[k]), 32'(pexp[k]));
                end
                tick();
            end
            for (int k = 0; k < NI; k++) chk("drain_empty", k, 32'(ov[k]), 32'd0);
            push1(32'h0202BEEF, 2'b00);
            tick();
            for (int k = 0; k < NI; k++) begin
                chk("after_tail_drop", k, 32'(dc[k]),  32'd2);
                chk("after_tail_count", k, 32'(cnt[k]), 32'd0);
            end
        end

        // reset mid-packet with three flits buffered
        out_ready = 1'b0;
        push1(32'h00020000, 2'b01);
        push1(32'h00001111, 2'b00);
        push1(32'h00002222, 2'b00);
        for (int k = 0; k < NI; k++) chk("mid_count", k, 32'(cnt[k]), 32'd3);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk("rst_mid_count", k, 32'(cnt[k]), 32'd0);
            chk("rst_mid_valid", k, 32'(ov[k]),  32'd0);
            chk("rst_mid_ready", k, 32'(ir[k]),  32'd1);
            chk("rst_mid_port",  k, 32'(op[k]),  32'd0);
            chk("rst_mid_drop",  k, 32'(dc[k]),  32'd0);
        end
        push1(32'h00003333, 2'b00);
        for (int k = 0; k < NI; k++) chk("rst_body_valid", k, 32'(ov[k]), 32'd0);
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_body_drop",  k, 32'(dc[k]),  32'd1);
            chk("rst_body_count", k, 32'(cnt[k]), 32'd0);
        end

        // drop counter saturation
        in_valid = 1'b1; in_type = 2'b10; in_data = 32'h0101FFFF;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("sat_drop",  k, 32'(dc[k]),  32'd255);
            chk("sat_count", k, 32'(cnt[k]), 32'd0);
        end

        // randomized traffic against the packet model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_type   = 2'($urandom_range(0, 3));
            in_data   = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 16'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
            reset = 1'b0;
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
